// File: rtl/serial_subtractor_nbit_if.sv
// Handshake/operand bundle for serial_subtractor_nbit.
// Build option: SUB_SIGNED_OVF_EN adds the signed overflow result line.
//   master: controller side, drives start/a/b/borrow_in and reads the results
//   slave : subtractor side, reads the request and drives the results
interface serial_subtractor_nbit_if #(
  parameter int unsigned NUMB_BITS = 4
);
  logic                 start;
  logic [NUMB_BITS-1:0] a;
  logic [NUMB_BITS-1:0] b;
  logic                 borrow_in;
  logic [NUMB_BITS-1:0] difference;
  logic                 borrow_out;
  logic                 busy;
  logic                 done;
`ifdef SUB_SIGNED_OVF_EN
  logic                 overflow;

  modport master (
    output start, a, b, borrow_in,
    input  difference, borrow_out, busy, done, overflow
  );
  modport slave (
    input  start, a, b, borrow_in,
    output difference, borrow_out, busy, done, overflow
  );
`else
  modport master (
    output start, a, b, borrow_in,
    input  difference, borrow_out, busy, done
  );
  modport slave (
    input  start, a, b, borrow_in,
    output difference, borrow_out, busy, done
  );
`endif
endinterface

// File: rtl/serial_subtractor_nbit.sv
// Bit-serial subtractor: difference = a - b - borrow_in, one bit per clock,
// LSB first, through a single full-subtractor cell.
// Build option: SUB_SIGNED_OVF_EN adds the registered bus.overflow result.
// Ports:
//   clk   - system clock, rising edge
//   n_rst - asynchronous active-low reset
//   bus   - slave side of serial_subtractor_nbit_if:
//           start/a/b/borrow_in request (sampled only on the accepting edge),
//           difference/borrow_out result registers, busy, done pulse
module serial_subtractor_nbit #(
  parameter int unsigned NUMB_BITS = 4
) (
  input  logic                         clk,
  input  logic                         n_rst,
  serial_subtractor_nbit_if.slave      bus
);

  localparam int unsigned CNT_W = $clog2(NUMB_BITS);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(NUMB_BITS - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]           state_q,  state_d;
  logic [NUMB_BITS-1:0] a_sr_q,   a_sr_d;
  logic [NUMB_BITS-1:0] b_sr_q,   b_sr_d;
  logic [NUMB_BITS-1:0] res_sr_q, res_sr_d;
  logic                 br_q,     br_d;
  logic [CNT_W-1:0]     cnt_q,    cnt_d;
  logic [NUMB_BITS-1:0] diff_q,   diff_d;
  logic                 bout_q,   bout_d;
  logic                 busy_q,   busy_d;
  logic                 done_q,   done_d;
`ifdef SUB_SIGNED_OVF_EN
  logic                 a_msb_q,  a_msb_d;
  logic                 b_msb_q,  b_msb_d;
  logic                 ovf_q,    ovf_d;
`endif

  // Full-subtractor cell on the current LSBs
  logic                 bit_d_c;
  logic                 bit_br_c;
  logic [NUMB_BITS-1:0] res_next_c;

  assign bit_d_c    = a_sr_q[0] ^ b_sr_q[0] ^ br_q;
  assign bit_br_c   = (~a_sr_q[0] & b_sr_q[0]) | (~(a_sr_q[0] ^ b_sr_q[0]) & br_q);
  assign res_next_c = {bit_d_c, res_sr_q[NUMB_BITS-1:1]};

  // Next-state and next-output logic
  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    res_sr_d = res_sr_q;
    br_d     = br_q;
    cnt_d    = cnt_q;
    diff_d   = diff_q;
    bout_d   = bout_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;
`ifdef SUB_SIGNED_OVF_EN
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    ovf_d    = ovf_q;
`endif

    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (bus.start) begin
          a_sr_d  = bus.a;
          b_sr_d  = bus.b;
          br_d    = bus.borrow_in;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = ST_SHIFT;
`ifdef SUB_SIGNED_OVF_EN
          a_msb_d = bus.a[NUMB_BITS-1];
          b_msb_d = bus.b[NUMB_BITS-1];
`endif
        end
      end
      ST_SHIFT: begin
        a_sr_d   = a_sr_q >> 1;
        b_sr_d   = b_sr_q >> 1;
        res_sr_d = res_next_c;
        br_d     = bit_br_c;
        cnt_d    = cnt_q + CNT_W'(1);
        busy_d   = 1'b1;
        if (cnt_q == LAST_BIT) begin
          diff_d  = res_next_c;
          bout_d  = bit_br_c;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_DONE;
`ifdef SUB_SIGNED_OVF_EN
          ovf_d   = (a_msb_q != b_msb_q) && (res_next_c[NUMB_BITS-1] != a_msb_q);
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= ST_IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      res_sr_q <= '0;
      br_q     <= 1'b0;
      cnt_q    <= '0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef SUB_SIGNED_OVF_EN
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      res_sr_q <= res_sr_d;
      br_q     <= br_d;
      cnt_q    <= cnt_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef SUB_SIGNED_OVF_EN
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign bus.difference = diff_q;
  assign bus.borrow_out = bout_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
`ifdef SUB_SIGNED_OVF_EN
  assign bus.overflow   = ovf_q;
`endif

endmodule
